// File: rtl/maze_pkg.sv
// Shared maze definitions: direction codes used by the location-update
// datapath and its inverse decoder, the coordinate limit, and the
// decoder FSM encoding.
package maze_pkg;

    // Direction codes. X moves iff ^dir == 1; dir[0] == 1 means +1.
    localparam logic [1:0] DIR_YDEC = 2'b00;
    localparam logic [1:0] DIR_XINC = 2'b01;
    localparam logic [1:0] DIR_XDEC = 2'b10;
    localparam logic [1:0] DIR_YINC = 2'b11;

    // Largest coordinate for the default 4-bit coordinate width.
    localparam logic [3:0] COORD_MAX = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_ERR   = 2'd3
    } decState_t;

endpackage

// File: rtl/dir_fifo.sv
// Small synchronous FIFO with a registered head output.
// Ports:
//   clk, rst    clock (rising edge), async active-low reset
//   push, pop   write / read strobes (ignored when full / empty)
//   flush       empties the FIFO, takes priority over push/pop
//   din, dout   write data / registered head-of-queue data
//   full, empty occupancy flags
//   oneLeft     exactly one entry stored
module dir_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic             oneLeft
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wrPtr;
    logic [PW-1:0]    rdPtr;
    logic [CW-1:0]    count;
    logic             doPush;
    logic             doPop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign oneLeft = (count == CW'(1));
    assign doPush  = push && !full;
    assign doPop   = pop && !empty;

    always_ff @(posedge clk) begin
        if (doPush && !flush) mem[wrPtr] <= din;
    end

    // Pointers are log2(DEPTH) wide, so they wrap modulo DEPTH on their own.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
            dout  <= '0;
        end else if (flush) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
            dout  <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + PW'(1);
            if (doPop)  rdPtr <= rdPtr + PW'(1);
            case ({doPush, doPop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            // Keep dout equal to the entry that will be at the head next cycle.
            if (doPop) begin
                if (count > CW'(1))
                    dout <= mem[rdPtr + PW'(1)];
                else if (doPush)
                    dout <= din;
            end else if (empty && doPush) begin
                dout <= din;
            end
        end
    end

endmodule

// File: rtl/loc_dir_decoder.sv
// Recovers move directions from a stream of successive maze locations
// {X,Y}; non-adjacent steps raise a sticky error. Directions are queued
// in dir_fifo for the replay/display logic.
// Ports:
//   clk, rst               clock, async active-low reset
//   start, origin          restart pulse and starting location
//   locIn, locLast,
//   locValid, locReady     location stream (valid/ready handshake)
//   dirOut, dirValid,
//   dirReady               direction stream from FIFO head
//   err, errLoc            sticky illegal-step flag and offending location
//   done                   pulse when the final direction has been popped
//
// state    | meaning
// ---------+------------------------------------------------------
// ST_IDLE  | waiting for start, no locations accepted
// ST_RUN   | accepting locations while FIFO has room
// ST_DRAIN | last location seen, waiting for FIFO to empty
// ST_ERR   | illegal step seen, FIFO drains, only start exits
module loc_dir_decoder
    import maze_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int COORD_W    = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [2*COORD_W-1:0] origin,
    input  logic [2*COORD_W-1:0] locIn,
    input  logic               locLast,
    input  logic               locValid,
    output logic               locReady,
    output logic [1:0]         dirOut,
    output logic               dirValid,
    input  logic               dirReady,
    output logic               err,
    output logic [2*COORD_W-1:0] errLoc,
    output logic               done
);
    localparam int LOC_W = 2 * COORD_W;

    decState_t          state;
    logic [LOC_W-1:0]   prev;
    logic [COORD_W-1:0] curX, curY, prvX, prvY;
    logic               xInc, xDec, yInc, yDec;
    logic               stepLegal;
    logic [1:0]         stepDir;
    logic               accept, push, pop;
    logic               fifoFull, fifoEmpty, fifoOneLeft;

    assign curX = locIn[LOC_W-1:COORD_W];
    assign curY = locIn[COORD_W-1:0];
    assign prvX = prev[LOC_W-1:COORD_W];
    assign prvY = prev[COORD_W-1:0];

    // Edge guards reject 0<->max wraps that the +-1 compare would otherwise allow.
    assign xInc = (curY == prvY) && (prvX != '1) && (curX == prvX + COORD_W'(1));
    assign xDec = (curY == prvY) && (prvX != '0) && (curX == prvX - COORD_W'(1));
    assign yInc = (curX == prvX) && (prvY != '1) && (curY == prvY + COORD_W'(1));
    assign yDec = (curX == prvX) && (prvY != '0) && (curY == prvY - COORD_W'(1));
    assign stepLegal = xInc || xDec || yInc || yDec;

    always_comb begin
        stepDir = DIR_YDEC;
        if (xInc)      stepDir = DIR_XINC;
        else if (xDec) stepDir = DIR_XDEC;
        else if (yInc) stepDir = DIR_YINC;
    end

    // locReady depends only on registered state, never on dirReady.
    assign locReady = (state == ST_RUN) && !fifoFull;
    assign accept   = locValid && locReady && !start;
    assign push     = accept && stepLegal;
    assign pop      = dirValid && dirReady;
    assign dirValid = !fifoEmpty;

    dir_fifo #(
        .WIDTH(2),
        .DEPTH(FIFO_DEPTH)
    ) uFifo (
        .clk    (clk),
        .rst    (rst),
        .push   (push),
        .pop    (pop),
        .flush  (start),
        .din    (stepDir),
        .dout   (dirOut),
        .full   (fifoFull),
        .empty  (fifoEmpty),
        .oneLeft(fifoOneLeft)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= ST_IDLE;
            prev   <= '0;
            err    <= 1'b0;
            errLoc <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                state  <= ST_RUN;
                prev   <= origin;
                err    <= 1'b0;
                errLoc <= '0;
            end else begin
                case (state)
                    ST_RUN: begin
                        if (accept) begin
                            if (stepLegal) begin
                                prev <= locIn;
                                if (locLast) state <= ST_DRAIN;
                            end else begin
                                err    <= 1'b1;
                                errLoc <= locIn;
                                state  <= ST_ERR;
                            end
                        end
                    end
                    ST_DRAIN: begin
                        if (pop && fifoOneLeft) begin
                            done  <= 1'b1;
                            state <= ST_IDLE;
                        end
                    end
                    default: state <= state;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_loc_dir_decoder.sv
module tb_loc_dir_decoder;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] origin;
    logic [7:0] locIn;
    logic       locLast;
    logic       locValid;
    logic       locReady;
    logic [1:0] dirOut;
    logic       dirValid;
    logic       dirReady;
    logic       err;
    logic [7:0] errLoc;
    logic       done;

    loc_dir_decoder #(.FIFO_DEPTH(DEPTH), .COORD_W(4)) dut (
        .clk(clk), .rst(rst), .start(start), .origin(origin),
        .locIn(locIn), .locLast(locLast), .locValid(locValid),
        .locReady(locReady), .dirOut(dirOut), .dirValid(dirValid),
        .dirReady(dirReady), .err(err), .errLoc(errLoc), .done(done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: path bookkeeping in plain integers and a queue.
    typedef enum {M_IDLE, M_RUN, M_DRAIN, M_ERR} mode_t;
    mode_t mMode;
    int    mq[$];
    int    mPrev, mErrLoc;
    bit    mErr, mDone, lastAcc;
    int    doneSeen;

    function automatic void modelReset();
        mq.delete();
        mMode = M_IDLE; mPrev = 0; mErr = 0; mErrLoc = 0; mDone = 0; lastAcc = 0;
    endfunction

    function automatic void modelStep();
        int  pre = mq.size();
        bit  acc = (mMode == M_RUN) && (pre < DEPTH) && locValid;
        bit  pp  = (pre > 0) && dirReady;
        int  dx, dy;
        mDone = 0; lastAcc = 0;
        if (start) begin
            mq.delete();
            mPrev = origin; mErr = 0; mErrLoc = 0; mMode = M_RUN;
        end else begin
            if (pp) void'(mq.pop_front());
            if (acc) begin
                lastAcc = 1;
                dx = int'(locIn[7:4]) - (mPrev / 16);
                dy = int'(locIn[3:0]) - (mPrev % 16);
                if ((dy == 0 && (dx == 1 || dx == -1)) || (dx == 0 && (dy == 1 || dy == -1))) begin
                    if (dx == 1)       mq.push_back(1);
                    else if (dx == -1) mq.push_back(2);
                    else if (dy == 1)  mq.push_back(3);
                    else               mq.push_back(0);
                    mPrev = locIn;
                    if (locLast) mMode = M_DRAIN;
                end else begin
                    mErr = 1; mErrLoc = locIn; mMode = M_ERR;
                end
            end
            if (mMode == M_DRAIN && pp && mq.size() == 0) begin
                mDone = 1; mMode = M_IDLE;
            end
        end
    endfunction

    task automatic compareAll();
        chk("locReady", locReady, (mMode == M_RUN) && (mq.size() < DEPTH));
        chk("dirValid", dirValid, mq.size() > 0);
        if (mq.size() > 0) chk("dirOut", dirOut, mq[0]);
        chk("err", err, mErr);
        chk("errLoc", errLoc, mErrLoc);
        chk("done", done, mDone);
        if (done) doneSeen++;
    endtask

    task automatic tick(input bit st, input logic [7:0] org, input logic [7:0] loc,
                        input bit last, input bit vld, input bit rdy);
        start = st; origin = org; locIn = loc; locLast = last;
        locValid = vld; dirReady = rdy;
        @(posedge clk);
        modelStep();
        #1;
        compareAll();
    endtask

    function automatic logic [7:0] neighbour(input int p);
        int x = p / 16, y = p % 16;
        logic [7:0] r;
        case ($urandom_range(0, 3))
            0: y = y - 1;
            1: x = x + 1;
            2: x = x - 1;
            default: y = y + 1;
        endcase
        r = {4'(x), 4'(y)};
        return r;
    endfunction

    logic [7:0] seq3 [5];
    int idx;

    initial begin
        modelReset();
        rst = 1'b0; start = 0; origin = 0; locIn = 0; locLast = 0;
        locValid = 0; dirReady = 0;
        #12;
        chk("rst_locReady", locReady, 0);
        chk("rst_dirValid", dirValid, 0);
        chk("rst_dirOut", dirOut, 0);
        chk("rst_err", err, 0);
        chk("rst_errLoc", errLoc, 0);
        chk("rst_done", done, 0);
        rst = 1'b1;
        @(negedge clk);

        // Scenario 1: closed square path.
        doneSeen = 0;
        tick(1, 8'h33, 8'h00, 0, 0, 1);
        tick(0, 8'h00, 8'h43, 0, 1, 1);
        tick(0, 8'h00, 8'h44, 0, 1, 1);
        tick(0, 8'h00, 8'h34, 0, 1, 1);
        tick(0, 8'h00, 8'h33, 1, 1, 1);
        for (int i = 0; i < 6; i++) tick(0, 8'h00, 8'h00, 0, 0, 1);
        chk("s1_donePulses", doneSeen, 1);
        chk("s1_idle_locReady", locReady, 0);

        // Scenario 2: Y wrap 0->15 is illegal, start clears err.
        tick(1, 8'h00, 8'h00, 0, 0, 1);
        tick(0, 8'h00, 8'h0F, 0, 1, 1);
        chk("s2_err", err, 1);
        chk("s2_errLoc", errLoc, 8'h0F);
        tick(0, 8'h00, 8'h01, 0, 1, 1);
        tick(1, 8'h00, 8'h00, 0, 0, 1);
        chk("s2_errCleared", err, 0);

        // Scenario 3: fill FIFO with dirReady low, then free one slot.
        seq3[0] = 8'h10; seq3[1] = 8'h20; seq3[2] = 8'h30; seq3[3] = 8'h40; seq3[4] = 8'h50;
        tick(1, 8'h00, 8'h00, 0, 0, 0);
        idx = 0;
        for (int i = 0; i < 8 && idx < 5; i++) begin
            tick(0, 8'h00, seq3[idx], 0, 1, 0);
            if (lastAcc) idx++;
        end
        chk("s3_acceptedWhileBlocked", idx, 4);
        tick(0, 8'h00, seq3[4], 0, 1, 1);
        tick(0, 8'h00, seq3[4], 0, 1, 0);
        chk("s3_fifthAccepted", lastAcc, 1);

        // Scenario 4: two entries, simultaneous push and pop.
        tick(1, 8'h55, 8'h00, 0, 0, 0);
        tick(0, 8'h00, 8'h56, 0, 1, 0);
        tick(0, 8'h00, 8'h66, 0, 1, 0);
        tick(0, 8'h00, 8'h65, 0, 1, 1);
        tick(0, 8'h00, 8'h64, 0, 1, 1);
        for (int i = 0; i < 4; i++) tick(0, 8'h00, 8'h00, 0, 0, 1);

        // Scenario 5: diagonal and repeated location.
        tick(1, 8'h33, 8'h00, 0, 0, 1);
        tick(0, 8'h00, 8'h44, 0, 1, 1);
        chk("s5_diagErrLoc", errLoc, 8'h44);
        tick(1, 8'h33, 8'h00, 0, 0, 1);
        tick(0, 8'h00, 8'h33, 0, 1, 1);
        chk("s5_repeatErr", err, 1);

        // Scenario 6: async reset with three queued entries.
        tick(1, 8'h33, 8'h00, 0, 0, 0);
        tick(0, 8'h00, 8'h43, 0, 1, 0);
        tick(0, 8'h00, 8'h44, 0, 1, 0);
        tick(0, 8'h00, 8'h34, 0, 1, 0);
        #2 rst = 1'b0;
        #1;
        modelReset();
        chk("s6_dirValid", dirValid, 0);
        chk("s6_locReady", locReady, 0);
        chk("s6_err", err, 0);
        @(negedge clk);
        rst = 1'b1;
        doneSeen = 0;
        tick(1, 8'h33, 8'h00, 0, 0, 1);
        tick(0, 8'h00, 8'h43, 0, 1, 1);
        tick(0, 8'h00, 8'h44, 0, 1, 1);
        tick(0, 8'h00, 8'h34, 0, 1, 1);
        tick(0, 8'h00, 8'h33, 1, 1, 1);
        for (int i = 0; i < 6; i++) tick(0, 8'h00, 8'h00, 0, 0, 1);
        chk("s6_donePulses", doneSeen, 1);

        // Randomised walks with occasional illegal steps and restarts.
        for (int i = 0; i < 3000; i++) begin
            bit st;
            logic [7:0] loc;
            st = (mMode != M_RUN) ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 99) == 0);
            loc = ($urandom_range(0, 99) < 12) ? 8'($urandom) : neighbour(mPrev);
            tick(st, 8'($urandom), loc, $urandom_range(0, 19) == 0,
                 $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
